divisor_flotante: RTL and testbench

Sequential divider for the team's 13-bit floating-point format (1b sign | 4b exponent | 8b mantissa, exponent bias 7). It computes the quotient of two operands with an iterative restoring division, one quotient bit per clock. It is the inverse operation of the combinational floating-point multiplier and shares its number format and field layout. The block takes a start/ready handshake on the input side and produces a one-cycle valid pulse with the result on the output side.

---
 rtl/divisor_flotante_pkg.sv | 37 +++
 rtl/divisor_flotante_if.sv | 34 +++
 rtl/divisor_flotante_paso_division.sv | 34 +++
 rtl/divisor_flotante.sv | 190 +++++++++++++++++++
 tb/tb_divisor_flotante.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/divisor_flotante_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fp13_pkg
//  Description : Shared definitions for the 13-bit floating-point format
//                {sign, exponent, mantissa}, value (-1)^s * 1.m * 2^(e-7).
//                Holds the field widths, bias, saturation constant and the
//                divider FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp13_pkg;

    localparam int SIGN_W  = 1;
    localparam int EXP_W   = 4;
    localparam int MANT_W  = 8;
    localparam int FP_W    = SIGN_W + EXP_W + MANT_W;

    localparam int BIAS    = 7;
    localparam int EXP_MAX = 15;
    localparam int ITER    = 10;

    // Largest representable magnitude: exponent and mantissa all ones.
    localparam logic [EXP_W+MANT_W-1:0] SATURADO = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIVIDE    = 2'd1,
        ST_NORMALIZE = 2'd2,
        ST_DONE      = 2'd3
    } estado_t;

    // Restore the hidden leading one of a stored mantissa.
    function automatic logic [MANT_W:0] f_mant_completa(input logic [MANT_W-1:0] m);
        return {1'b1, m};
    endfunction

endpackage
`default_nettype wire

// File: rtl/divisor_flotante_if.sv
`default_nettype none
// ============================================================================
//  Interface   : divisor_flotante_if
//  Description : Request/result bundle of the floating-point divider. Signal
//                directions are named from the divider's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface divisor_flotante_if;
    import fp13_pkg::*;

    logic              i_start;
    logic [FP_W-1:0]   i_dividendo;
    logic [FP_W-1:0]   i_divisor;
    logic              o_ready;
    logic              o_valid;
    logic [FP_W-1:0]   o_cociente;
    logic              o_div_cero;
    logic              o_overflow;
    logic              o_underflow;

    // Divider side.
    modport slave (
        input  i_start, i_dividendo, i_divisor,
        output o_ready, o_valid, o_cociente, o_div_cero, o_overflow, o_underflow
    );

    // Requester side.
    modport master (
        output i_start, i_dividendo, i_divisor,
        input  o_ready, o_valid, o_cociente, o_div_cero, o_overflow, o_underflow
    );

endinterface
`default_nettype wire

// File: rtl/divisor_flotante_paso_division.sv
`default_nettype none
// ============================================================================
//  Module      : paso_division
//  Description : One combinational restoring-division step. Compares the
//                partial remainder with the divisor, subtracts when it fits,
//                and shifts the remainder left for the next quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module paso_division
    import fp13_pkg::*;
(
    input  wire logic [MANT_W+1:0] i_resto,
    input  wire logic [MANT_W:0]   i_divisor,
    output logic      [MANT_W+1:0] o_resto,
    output logic                   o_bit
);

    logic [MANT_W+1:0] w_divisor_ext;
    logic [MANT_W+1:0] w_diferencia;
    logic [MANT_W+1:0] w_restaurado;

    assign w_divisor_ext = {1'b0, i_divisor};
    assign w_diferencia  = i_resto - w_divisor_ext;
    assign o_bit         = (i_resto >= w_divisor_ext);

    // Keep the difference only when the divisor fitted; otherwise restore.
    assign w_restaurado  = o_bit ? w_diferencia : i_resto;

    // After a successful step the remainder is below the divisor, so the
    // dropped MSB is always zero.
    assign o_resto       = w_restaurado << 1;

endmodule
`default_nettype wire

// File: rtl/divisor_flotante.sv
`default_nettype none
// ============================================================================
//  Module      : divisor_flotante
//  Description : Sequential 13-bit floating-point divider. Restoring division
//                of the mantissas, one quotient bit per clock over 10 cycles,
//                then truncating normalisation with zero/overflow/underflow
//                and divide-by-zero handling. Fixed 11-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module divisor_flotante
    import fp13_pkg::*;
(
    input  wire logic          i_clock,
    input  wire logic          i_reset_n,
    divisor_flotante_if.slave  bus
);

    localparam logic [3:0]        C_ULTIMA_ITER = 4'(ITER - 1);
    localparam logic signed [5:0] C_EXP_MAX     = 6'(EXP_MAX);
    localparam logic signed [5:0] C_SESGO_ALTO  = 6'(BIAS);
    localparam logic signed [5:0] C_SESGO_BAJO  = 6'(BIAS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    estado_t             r_estado;
    estado_t             w_estado_sig;
    logic [3:0]          r_cnt;
    logic [MANT_W+1:0]   r_resto;
    logic [MANT_W+1:0]   r_q;
    logic [MANT_W:0]     r_divisor_m;
    logic                r_signo;
    logic [EXP_W-1:0]    r_e1;
    logic [EXP_W-1:0]    r_e2;

    logic [FP_W-1:0]     r_cociente;
    logic                r_div_cero;
    logic                r_overflow;
    logic                r_underflow;

    // FSM strobes
    logic                w_ready;
    logic                w_valid;
    logic                w_aceptar;
    logic                w_iterar;
    logic                w_normalizar;

    // Division step
    logic [MANT_W+1:0]   w_resto_sig;
    logic                w_bit;

    // Normalisation
    logic signed [5:0]   w_e1;
    logic signed [5:0]   w_e2;
    logic signed [5:0]   w_sesgo;
    logic signed [5:0]   w_exp;
    logic [MANT_W-1:0]   w_mant;
    logic [FP_W-1:0]     w_res;
    logic                w_dz;
    logic                w_ov;
    logic                w_uf;

    // ------------------------------------------------------------------
    // Single shared division step, reused every DIVIDE cycle
    // ------------------------------------------------------------------
    paso_division u_paso (
        .i_resto   (r_resto),
        .i_divisor (r_divisor_m),
        .o_resto   (w_resto_sig),
        .o_bit     (w_bit)
    );

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        w_estado_sig = r_estado;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        w_aceptar    = 1'b0;
        w_iterar     = 1'b0;
        w_normalizar = 1'b0;
        case (r_estado)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_start) begin
                    w_aceptar    = 1'b1;
                    w_estado_sig = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                w_iterar = 1'b1;
                if (r_cnt == C_ULTIMA_ITER) begin
                    w_estado_sig = ST_NORMALIZE;
                end
            end
            ST_NORMALIZE: begin
                w_normalizar = 1'b1;
                w_estado_sig = ST_DONE;
            end
            ST_DONE: begin
                w_valid      = 1'b1;
                w_estado_sig = ST_IDLE;
            end
            default: begin
                w_estado_sig = ST_IDLE;
            end
        endcase
    end

    // Exponent arithmetic in signed 6 bits; the quotient MSB selects whether
    // the mantissa ratio was >= 1 (bias 7) or in [0.5, 1) (bias 6).
    assign w_e1    = $signed({2'b00, r_e1});
    assign w_e2    = $signed({2'b00, r_e2});
    assign w_sesgo = r_q[MANT_W+1] ? C_SESGO_ALTO : C_SESGO_BAJO;
    assign w_exp   = w_e1 - w_e2 + w_sesgo;
    assign w_mant  = r_q[MANT_W+1] ? r_q[MANT_W:1] : r_q[MANT_W-1:0];

    // Result selection with special cases in priority order.
    always_comb begin
        w_res = {r_signo, w_exp[EXP_W-1:0], w_mant};
        w_dz  = 1'b0;
        w_ov  = 1'b0;
        w_uf  = 1'b0;
        if (r_e2 == '0) begin
            w_res = {r_signo, SATURADO};
            w_dz  = 1'b1;
        end else if (r_e1 == '0) begin
            w_res = '0;
        end else if (w_exp > C_EXP_MAX) begin
            w_res = {r_signo, SATURADO};
            w_ov  = 1'b1;
        end else if (w_exp <= 6'sd0) begin
            w_res = '0;
            w_uf  = 1'b1;
        end
    end

    // Operand capture, iterative division and result registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_resto     <= '0;
            r_q         <= '0;
            r_divisor_m <= '0;
            r_signo     <= 1'b0;
            r_e1        <= '0;
            r_e2        <= '0;
            r_cociente  <= '0;
            r_div_cero  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (w_aceptar) begin
            r_signo     <= bus.i_dividendo[FP_W-1] ^ bus.i_divisor[FP_W-1];
            r_e1        <= bus.i_dividendo[MANT_W +: EXP_W];
            r_e2        <= bus.i_divisor[MANT_W +: EXP_W];
            r_divisor_m <= f_mant_completa(bus.i_divisor[MANT_W-1:0]);
            // The dividend mantissa seeds the remainder; since M1 < 2*M2 the
            // first step already yields the quotient's weight-512 bit.
            r_resto     <= {1'b0, f_mant_completa(bus.i_dividendo[MANT_W-1:0])};
            r_q         <= '0;
            r_cnt       <= '0;
        end else if (w_iterar) begin
            r_resto     <= w_resto_sig;
            r_q         <= {r_q[MANT_W:0], w_bit};
            r_cnt       <= r_cnt + 4'd1;
        end else if (w_normalizar) begin
            r_cociente  <= w_res;
            r_div_cero  <= w_dz;
            r_overflow  <= w_ov;
            r_underflow <= w_uf;
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_valid     = w_valid;
    assign bus.o_cociente  = r_cociente;
    assign bus.o_div_cero  = r_div_cero;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_divisor_flotante.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divisor_flotante
//  Description : Scoreboard bench for divisor_flotante. The driver pushes the
//                hand-computed result of each accepted request; a monitor pops
//                and compares whenever o_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_flotante;
    import fp13_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    divisor_flotante_if bus ();

    divisor_flotante dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    typedef struct {
        logic [12:0] q;
        logic        dz;
        logic        ov;
        logic        uf;
        int          k;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   n_valid = 0;
    int   n_acc   = 0;

    // Edge counter: after rising edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: compare every presented result with the oldest expectation.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && bus.o_valid === 1'b1) begin
            n_valid++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("cociente",  32'(bus.o_cociente),  32'(e.q));
                chk("div_cero",  32'(bus.o_div_cero),  32'(e.dz));
                chk("overflow",  32'(bus.o_overflow),  32'(e.ov));
                chk("underflow", 32'(bus.o_underflow), 32'(e.uf));
                chk("latency",   32'(cyc - e.k),       32'd11);
            end
        end
    end

    // Wait for o_ready, present one request for one edge, record expectation.
    task automatic issue(input logic [12:0] a, input logic [12:0] b,
                         input logic [12:0] qe, input logic dz, input logic ov,
                         input logic uf);
        int w = 0;
        @(negedge clk);
        while (bus.o_ready !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got o_ready=%b expected 1 within 60 cycles", bus.o_ready);
        end
        bus.i_start     = 1'b1;
        bus.i_dividendo = a;
        bus.i_divisor   = b;
        sb.push_back('{qe, dz, ov, uf, cyc + 1});
        n_acc++;
        @(posedge clk);
        #1;
        bus.i_start     = 1'b0;
        bus.i_dividendo = 13'h1555;
        bus.i_divisor   = 13'h0AAA;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lowcnt;
        bus.i_start     = 1'b0;
        bus.i_dividendo = '0;
        bus.i_divisor   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready",     32'(bus.o_ready),     32'd1);
        chk("rst_valid",     32'(bus.o_valid),     32'd0);
        chk("rst_cociente",  32'(bus.o_cociente),  32'd0);
        chk("rst_div_cero",  32'(bus.o_div_cero),  32'd0);
        chk("rst_overflow",  32'(bus.o_overflow),  32'd0);
        chk("rst_underflow", 32'(bus.o_underflow), 32'd0);
        rst_n = 1'b1;

        // Normal quotients.
        issue(13'h0800, 13'h0700, 13'h0800, 0, 0, 0);  // 2 / 1
        issue(13'h0700, 13'h0800, 13'h0600, 0, 0, 0);  // 1 / 2
        issue(13'h0700, 13'h0780, 13'h0655, 0, 0, 0);  // 1 / 1.5 truncated
        issue(13'h0780, 13'h1700, 13'h1780, 0, 0, 0);  // 1.5 / -1
        issue(13'h0F00, 13'h0700, 13'h0F00, 0, 0, 0);  // exponent exactly 15
        issue(13'h0100, 13'h0700, 13'h0100, 0, 0, 0);  // exponent exactly 1
        // Zero operands.
        issue(13'h0700, 13'h0000, 13'h0FFF, 1, 0, 0);
        issue(13'h0000, 13'h0000, 13'h0FFF, 1, 0, 0);
        issue(13'h1700, 13'h0000, 13'h1FFF, 1, 0, 0);  // saturation keeps sign
        issue(13'h0000, 13'h0700, 13'h0000, 0, 0, 0);
        issue(13'h1000, 13'h0700, 13'h0000, 0, 0, 0);  // zero result has sign 0
        // Range limits.
        issue(13'h0100, 13'h0F00, 13'h0000, 0, 0, 1);
        issue(13'h0100, 13'h0780, 13'h0000, 0, 0, 1);  // exponent exactly 0
        issue(13'h0FFF, 13'h0100, 13'h0FFF, 0, 1, 0);
        drain();

        // Requests while busy are ignored; o_ready low for 12 cycles.
        issue(13'h0780, 13'h1700, 13'h1780, 0, 0, 0);
        lowcnt = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bus.o_ready === 1'b0) lowcnt++;
            if (i == 3 || i == 7) begin
                bus.i_start     = 1'b1;
                bus.i_dividendo = 13'h0700;
                bus.i_divisor   = 13'h0780;
            end else begin
                bus.i_start     = 1'b0;
            end
        end
        bus.i_start = 1'b0;
        chk("ready_low_cycles", 32'(lowcnt), 32'd12);
        drain();
        repeat (20) @(negedge clk);
        chk("valid_count_busy", 32'(n_valid), 32'(n_acc));

        // Asynchronous reset during DIVIDE aborts the operation.
        issue(13'h0FFF, 13'h0100, 13'h0FFF, 0, 1, 0);
        drain();
        issue(13'h0780, 13'h0700, 13'h0780, 0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        n_acc--;
        chk("abort_ready",     32'(bus.o_ready),     32'd1);
        chk("abort_valid",     32'(bus.o_valid),     32'd0);
        chk("abort_cociente",  32'(bus.o_cociente),  32'd0);
        chk("abort_overflow",  32'(bus.o_overflow),  32'd0);
        chk("abort_div_cero",  32'(bus.o_div_cero),  32'd0);
        chk("abort_underflow", 32'(bus.o_underflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        issue(13'h0700, 13'h0780, 13'h0655, 0, 0, 0);
        drain();
        repeat (15) @(negedge clk);
        chk("valid_count_final", 32'(n_valid), 32'(n_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
